// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register for the pipelined MIPS core: valid/ready handshake, 2-entry skid, flush.
// Optional stall/flush statistics counters are built when PIPE_STAGE_REG_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int NUM_DATA = 3,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       pipe_stage_reg_clk_i,
  input  logic                       pipe_stage_reg_rstn_i,
  input  logic                       pipe_stage_reg_flush_i,
  input  logic                       pipe_stage_reg_valid_i,
  output logic                       pipe_stage_reg_ready_o,
  input  logic [31:0]                pipe_stage_reg_str_i,
  input  logic [PC_W-1:0]            pipe_stage_reg_pc4_i,
  input  logic [NUM_DATA*DATA_W-1:0] pipe_stage_reg_data_i,
  output logic                       pipe_stage_reg_valid_o,
  input  logic                       pipe_stage_reg_ready_i,
  output logic [31:0]                pipe_stage_reg_str_o,
  output logic [PC_W-1:0]            pipe_stage_reg_pc4_o,
  output logic [NUM_DATA*DATA_W-1:0] pipe_stage_reg_data_o,
  output logic [1:0]                 pipe_stage_reg_occ_o
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  output logic [31:0]                pipe_stage_reg_stall_cnt_o,
  output logic [31:0]                pipe_stage_reg_flush_cnt_o
`endif
);

  localparam int DW = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t          state;
  logic [31:0]     main_str, skid_str;
  logic [PC_W-1:0] main_pc4, skid_pc4;
  logic [DW-1:0]   main_data, skid_data;
  logic            in_fire, out_fire;

  // Handshake outputs decode registered state only, so ready never depends on ready_i.
  assign pipe_stage_reg_ready_o = (state != FULL);
  assign pipe_stage_reg_valid_o = (state != EMPTY);
  assign pipe_stage_reg_occ_o   = (state == FULL) ? 2'd2 : (state == BUSY) ? 2'd1 : 2'd0;

  assign in_fire  = pipe_stage_reg_valid_i & pipe_stage_reg_ready_o;
  assign out_fire = pipe_stage_reg_valid_o & pipe_stage_reg_ready_i;

  assign pipe_stage_reg_str_o  = main_str;
  assign pipe_stage_reg_pc4_o  = main_pc4;
  assign pipe_stage_reg_data_o = main_data;

  always_ff @(posedge pipe_stage_reg_clk_i or negedge pipe_stage_reg_rstn_i) begin
    if (!pipe_stage_reg_rstn_i) begin
      state     <= EMPTY;
      main_str  <= '0;
      main_pc4  <= RESET_PC;
      main_data <= '0;
      skid_str  <= '0;
      skid_pc4  <= RESET_PC;
      skid_data <= '0;
    end else if (pipe_stage_reg_flush_i) begin
      state     <= EMPTY;
      main_str  <= '0;
      main_pc4  <= RESET_PC;
      main_data <= '0;
      skid_str  <= '0;
      skid_pc4  <= RESET_PC;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_str  <= pipe_stage_reg_str_i;
            main_pc4  <= pipe_stage_reg_pc4_i;
            main_data <= pipe_stage_reg_data_i;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_str  <= pipe_stage_reg_str_i;
            main_pc4  <= pipe_stage_reg_pc4_i;
            main_data <= pipe_stage_reg_data_i;
          end else if (in_fire) begin
            skid_str  <= pipe_stage_reg_str_i;
            skid_pc4  <= pipe_stage_reg_pc4_i;
            skid_data <= pipe_stage_reg_data_i;
            state     <= FULL;
          end else if (out_fire) begin
            // Drop back to the bubble so a stale payload is never visible while empty.
            main_str  <= '0;
            main_pc4  <= RESET_PC;
            main_data <= '0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_str  <= skid_str;
            main_pc4  <= skid_pc4;
            main_data <= skid_data;
            skid_str  <= '0;
            skid_pc4  <= RESET_PC;
            skid_data <= '0;
            state     <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_REG_STATS_EN
  always_ff @(posedge pipe_stage_reg_clk_i or negedge pipe_stage_reg_rstn_i) begin
    if (!pipe_stage_reg_rstn_i) begin
      pipe_stage_reg_stall_cnt_o <= '0;
      pipe_stage_reg_flush_cnt_o <= '0;
    end else begin
      if (pipe_stage_reg_valid_o && !pipe_stage_reg_ready_i && (pipe_stage_reg_stall_cnt_o != 32'hFFFF_FFFF))
        pipe_stage_reg_stall_cnt_o <= pipe_stage_reg_stall_cnt_o + 32'd1;
      if (pipe_stage_reg_flush_i && (state != EMPTY) && (pipe_stage_reg_flush_cnt_o != 32'hFFFF_FFFF))
        pipe_stage_reg_flush_cnt_o <= pipe_stage_reg_flush_cnt_o + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based reference model.
// Stats counters are also checked when PIPE_STAGE_REG_STATS_EN is defined.
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int NUM_DATA = 3;
  localparam int PC_W = 32;
  localparam int DW = NUM_DATA * DATA_W;
  localparam int EW = 32 + PC_W + DW;
  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [31:0]   up_str = '0;
  logic [PC_W-1:0] up_pc4 = '0;
  logic [DW-1:0] up_data = '0;
  logic          dn_valid;
  logic          dn_ready = 1'b0;
  logic [31:0]   dn_str;
  logic [PC_W-1:0] dn_pc4;
  logic [DW-1:0] dn_data;
  logic [1:0]    occ;
`ifdef PIPE_STAGE_REG_STATS_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: entries held, in arrival order; the head is what the outputs show.
  logic [EW-1:0] model_q[$];
  logic [31:0]   model_stall = '0;
  logic [31:0]   model_flush = '0;

  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .pipe_stage_reg_clk_i  (clk),
    .pipe_stage_reg_rstn_i (rst_n),
    .pipe_stage_reg_flush_i(flush),
    .pipe_stage_reg_valid_i(up_valid),
    .pipe_stage_reg_ready_o(up_ready),
    .pipe_stage_reg_str_i  (up_str),
    .pipe_stage_reg_pc4_i  (up_pc4),
    .pipe_stage_reg_data_i (up_data),
    .pipe_stage_reg_valid_o(dn_valid),
    .pipe_stage_reg_ready_i(dn_ready),
    .pipe_stage_reg_str_o  (dn_str),
    .pipe_stage_reg_pc4_o  (dn_pc4),
    .pipe_stage_reg_data_o (dn_data),
    .pipe_stage_reg_occ_o  (occ)
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    .pipe_stage_reg_stall_cnt_o(stall_cnt),
    .pipe_stage_reg_flush_cnt_o(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [EW-1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : {32'h0, RESET_PC, {DW{1'b0}}};
    check("valid", EW'(dn_valid), EW'(model_q.size() > 0));
    check("ready", EW'(up_ready), EW'(model_q.size() < 2));
    check("occ", EW'(occ), EW'(model_q.size()));
    check("str", EW'(dn_str), EW'(head[EW-1 -: 32]));
    check("pc4", EW'(dn_pc4), EW'(head[DW +: PC_W]));
    check("data", EW'(dn_data), EW'(head[DW-1:0]));
`ifdef PIPE_STAGE_REG_STATS_EN
    check("stall_cnt", EW'(stall_cnt), EW'(model_stall));
    check("flush_cnt", EW'(flush_cnt), EW'(model_flush));
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic [PC_W-1:0] p,
                       input logic [DW-1:0] d, input logic r, input logic f);
    up_valid = v; up_str = s; up_pc4 = p; up_data = d; dn_ready = r; flush = f;
  endtask

  // One clock: advance the model from the driven inputs, then compare after the edge.
  task automatic step();
    bit take, give;
    @(posedge clk);
    take = up_valid && (model_q.size() < 2);
    give = (model_q.size() > 0) && dn_ready;
    if ((model_q.size() > 0) && !dn_ready && (model_stall != 32'hFFFF_FFFF)) model_stall++;
    if (flush && (model_q.size() > 0) && (model_flush != 32'hFFFF_FFFF)) model_flush++;
    if (flush) model_q.delete();
    else begin
      if (give) void'(model_q.pop_front());
      if (take) model_q.push_back({up_str, up_pc4, up_data});
    end
    #1;
    check_model();
    $display("cyc t=%0t v=%0b r=%0b fl=%0b -> vo=%0b ro=%0b occ=%0d str=%h pc4=%h",
             $time, up_valid, dn_ready, flush, dn_valid, up_ready, occ, dn_str, dn_pc4);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < NUM_DATA; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  logic [31:0] stream_str[3];
  logic [31:0] stream_pc[3];
  logic [31:0] a_str, b_str;
  logic [31:0] stall0, flush0;

  initial begin
    stream_str[0] = 32'h8C01_0004; stream_str[1] = 32'h0022_1820; stream_str[2] = 32'hAC03_0008;
    stream_pc[0] = 32'h3004; stream_pc[1] = 32'h3008; stream_pc[2] = 32'h300C;
    a_str = 32'h1111_AAAA; b_str = 32'h2222_BBBB;

    // Reset then idle
    #12 rst_n = 1'b1;
    #1 check_model();
    check("rst_pc4", EW'(dn_pc4), EW'(32'h3000));
    step();

    // Streaming: back-to-back, one cycle latency, occupancy stays at 1
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, stream_str[i], stream_pc[i], rnd_data(), 1'b1, 1'b0);
      step();
      check("stream_str", EW'(dn_str), EW'(stream_str[i]));
      check("stream_pc4", EW'(dn_pc4), EW'(stream_pc[i]));
      check("stream_occ", EW'(occ), EW'(1));
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Skid fill, then drain in order
    drive(1'b1, a_str, 32'h3010, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b1, b_str, 32'h3014, rnd_data(), 1'b0, 1'b0); step();
    check("skid_occ", EW'(occ), EW'(2));
    check("skid_ready", EW'(up_ready), EW'(0));
    check("skid_head", EW'(dn_str), EW'(a_str));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0); step();
    check("drain_b", EW'(dn_str), EW'(b_str));
    check("drain_ready", EW'(up_ready), EW'(1));
    step();

    // Flush while FULL drops the incoming entry C
    drive(1'b1, a_str, 32'h3020, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b1, b_str, 32'h3024, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b1, 32'hCCCC_CCCC, 32'h3028, rnd_data(), 1'b0, 1'b1); step();
    check("flush_valid", EW'(dn_valid), EW'(0));
    check("flush_str", EW'(dn_str), EW'(0));
    check("flush_pc4", EW'(dn_pc4), EW'(32'h3000));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0); step(); step();

    // Async reset while FULL
    drive(1'b1, a_str, 32'h3030, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b1, b_str, 32'h3034, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_q.delete(); model_stall = '0; model_flush = '0;
    #1 check_model();
    check("arst_occ", EW'(occ), EW'(0));
    #3 rst_n = 1'b1;
    drive(1'b1, 32'h3C01_1234, 32'h3040, rnd_data(), 1'b1, 1'b0); step();
    check("post_rst_str", EW'(dn_str), EW'(32'h3C01_1234));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0); step();

    // Stats: five stalled cycles with the stage holding data, then one flush with occ 2
    stall0 = model_stall; flush0 = model_flush;
    drive(1'b1, a_str, 32'h3050, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b1, b_str, 32'h3054, rnd_data(), 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1); step();
`ifdef PIPE_STAGE_REG_STATS_EN
    check("stats_stall5", EW'(stall_cnt - stall0), EW'(5));
    check("stats_flush1", EW'(flush_cnt - flush0), EW'(1));
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, PC_W'($urandom), rnd_data(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
